// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. It returns hits with no stall and refills a whole
// 128-bit block on a miss. Define ICACHE_STATS_EN to add saturating hit_count/miss_count ports.
module instruction_cache #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_BITS   = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 mem_read,
  output logic [ADDR_BITS-5:0] mem_address,
  input  logic [127:0]         mem_readdata,
  input  logic                 mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int OFF_BITS = $clog2(BLOCK_WORDS);
  localparam int IDX_BITS = $clog2(NUM_BLOCKS);
  localparam int BLK_LSB  = OFF_BITS + 2;
  localparam int BLK_BITS = ADDR_BITS - BLK_LSB;
  localparam int TAG_BITS = BLK_BITS - IDX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_BLOCKS-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
  logic [TAG_BITS-1:0]   tag_d  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];
  logic [127:0]          data_d [NUM_BLOCKS];
  logic                  first_q, first_d;
  logic                  mem_read_q, mem_read_d;
  logic [BLK_BITS-1:0]   mem_address_q, mem_address_d;
  logic [31:0]           instr_q, instr_d;

  logic [OFF_BITS-1:0]   pc_offset_s;
  logic [IDX_BITS-1:0]   pc_index_s;
  logic [TAG_BITS-1:0]   pc_tag_s;
  logic [BLK_BITS-1:0]   pc_block_s;
  logic [IDX_BITS-1:0]   upd_index_s;
  logic [TAG_BITS-1:0]   upd_tag_s;
  logic                  pc_skip_s;
  logic                  hit_s;
  logic                  idle_hit_s;
  logic                  idle_miss_s;
  logic [31:0]           hit_word_s;
  logic                  pc_unused_s;

  assign pc_unused_s = ^PC[1:0];

  // Address decode, hit detection and the combinational CPU-facing outputs.
  always_comb begin
    pc_offset_s = PC[BLK_LSB-1:2];
    pc_index_s  = PC[BLK_LSB+IDX_BITS-1:BLK_LSB];
    pc_tag_s    = PC[ADDR_BITS-1:BLK_LSB+IDX_BITS];
    pc_block_s  = PC[ADDR_BITS-1:BLK_LSB];
    upd_index_s = mem_address_q[IDX_BITS-1:0];
    upd_tag_s   = mem_address_q[BLK_BITS-1:IDX_BITS];
    // The CPU's pre-reset PC (-4) must never start a refill.
    pc_skip_s   = &PC[31:2];
    hit_s       = valid_q[pc_index_s] && (tag_q[pc_index_s] == pc_tag_s);
    hit_word_s  = data_q[pc_index_s][32*pc_offset_s +: 32];
    idle_hit_s  = (state_q == IDLE) && hit_s;
    idle_miss_s = (state_q == IDLE) && !hit_s && !pc_skip_s;
    BUSYWAIT    = RESET && ((state_q != IDLE) || idle_miss_s);
    INSTRUCTION = idle_hit_s ? hit_word_s : instr_q;
    mem_read    = mem_read_q;
    mem_address = mem_address_q;
  end

  // Refill FSM next-state, line write-back and held-instruction update.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    first_d       = 1'b0;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    instr_d       = idle_hit_s ? hit_word_s : instr_q;
    case (state_q)
      IDLE: begin
        if (idle_miss_s) begin
          state_d       = MEM_READ;
          first_d       = 1'b1;
          mem_read_d    = 1'b1;
          mem_address_d = pc_block_s;
        end else begin
          mem_read_d    = 1'b0;
        end
      end
      MEM_READ: begin
        // Memory only owns mem_busywait from the second request cycle on.
        if (!first_q && !mem_busywait) begin
          state_d    = UPDATE;
          mem_read_d = 1'b0;
        end else begin
          mem_read_d = 1'b1;
        end
      end
      UPDATE: begin
        valid_d[upd_index_s] = 1'b1;
        tag_d[upd_index_s]   = upd_tag_s;
        data_d[upd_index_s]  = mem_readdata;
        state_d              = IDLE;
        mem_read_d           = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase
  end

  // Cache state registers; reset aborts any refill and invalidates every line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      valid_q       <= {NUM_BLOCKS{1'b0}};
      first_q       <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= {BLK_BITS{1'b0}};
      instr_q       <= 32'd0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_q[i]  <= {TAG_BITS{1'b0}};
        data_q[i] <= 128'd0;
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      first_q       <= first_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      instr_q       <= instr_d;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic        last_pc_vld_q, last_pc_vld_d;
  logic        count_hit_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    sat_inc = (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  // A held PC counts as one hit; every refill start counts as one miss.
  always_comb begin
    count_hit_s = idle_hit_s && (!last_pc_vld_q || (PC != last_pc_q));
    if (count_hit_s) begin
      hit_cnt_d     = sat_inc(hit_cnt_q);
      last_pc_d     = PC;
      last_pc_vld_d = 1'b1;
    end else begin
      hit_cnt_d     = hit_cnt_q;
      last_pc_d     = last_pc_q;
      last_pc_vld_d = last_pc_vld_q;
    end
    if (idle_miss_s) begin
      miss_cnt_d = sat_inc(miss_cnt_q);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q     <= 16'd0;
      miss_cnt_q    <= 16'd0;
      last_pc_q     <= 32'd0;
      last_pc_vld_q <= 1'b0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised scoreboard bench for instruction_cache: a line-level cache model predicts instruction,
// stall length and refill reads; a monitor compares them whenever BUSYWAIT falls.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          stall;
    int          reads;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_words [256];
  bit          line_vld [8];
  int          line_blk [8];
  int          mem_lat = 1;
  logic [5:0]  exp_addr = 6'd0;
  logic [31:0] hold_exp = 32'd0;
  int          model_hits = 0;
  int          model_misses = 0;
  logic [31:0] last_pc = 32'd0;
  bit          last_pc_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: block data is always presented for the requested block; busywait stays high for
  // mem_lat request cycles, so the memory is occupied N = mem_lat + 1 cycles per refill.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      mem_readdata[32*w +: 32] = mem_words[4*int'(mem_address) + w];
    end
  end

  initial begin
    int  k;
    bit  active;
    mem_busywait = 1'b0;
    active = 1'b0;
    k = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (RESET && mem_read) begin
        if (!active) begin
          active = 1'b1;
          k = 0;
          check("mem_address", 32'(mem_address), 32'(exp_addr));
        end else begin
          k++;
        end
        mem_busywait = (k < mem_lat);
      end else begin
        active = 1'b0;
        mem_busywait = 1'b0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) line_vld[i] = 1'b0;
    hold_exp     = 32'd0;
    model_hits   = 0;
    model_misses = 0;
    last_pc_vld  = 1'b0;
  endtask

  // Present one fetch: predict it from the line model and hand the expectation to the monitor.
  task automatic issue(input logic [31:0] pc, input int lat);
    exp_t e;
    int   idx;
    int   blk;
    bit   miss;
    if (RESET) check("pc_change_while_busy", 32'(BUSYWAIT), 32'd0);
    idx  = int'((pc >> 4) % 8);
    blk  = int'((pc >> 4) % 64);
    miss = !(line_vld[idx] && line_blk[idx] == blk);
    e.pc    = pc;
    e.instr = mem_words[(pc >> 2) % 256];
    e.stall = miss ? lat + 3 : 0;
    e.reads = miss ? lat + 1 : 0;
    if (miss) begin
      line_vld[idx] = 1'b1;
      line_blk[idx] = blk;
      if (model_misses < 65535) model_misses++;
    end
    if (!last_pc_vld || pc != last_pc) begin
      if (model_hits < 65535) model_hits++;
      last_pc     = pc;
      last_pc_vld = 1'b1;
    end
    mem_lat  = lat;
    exp_addr = blk[5:0];
    PC       = pc;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSYWAIT && n < 40);
    check("stall_timeout", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
`ifdef ICACHE_STATS_EN
    check("hit_count", 32'(hit_count), 32'(model_hits));
    check("miss_count", 32'(miss_count), 32'(model_misses));
`endif
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    PC    = 32'hFFFF_FFFC;
    sb_q.delete();
    model_reset();
    #1;
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_instruction", INSTRUCTION, 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: accumulates stall and read cycles, then scores the fetch when BUSYWAIT is low.
  initial begin
    int   stall = 0;
    int   reads = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        stall = 0;
        reads = 0;
      end else if (sb_q.size() == 0) begin
        check("idle_mem_read", 32'(mem_read), 32'd0);
        check("idle_busywait", 32'(BUSYWAIT), 32'd0);
      end else if (BUSYWAIT) begin
        stall++;
        if (mem_read) reads++;
        check("held_instruction", INSTRUCTION, hold_exp);
      end else begin
        e = sb_q.pop_front();
        check("instruction", INSTRUCTION, e.instr);
        check("stall_cycles", 32'(stall), 32'(e.stall));
        check("mem_read_cycles", 32'(reads), 32'(e.reads));
        hold_exp = e.instr;
        stall = 0;
        reads = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    RESET = 1'b1;
    PC    = 32'hFFFF_FFFC;
    for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_words[i] = 32'(i + 1);
    #2;
    do_reset();

    // Cold miss on block 0; N = 5 gives a 7-cycle stall.
    issue(32'h0000_0000, 4);
    wait_done();

    // Sequential hits in the same block.
    issue(32'h0000_0004, 1);
    wait_done();
    issue(32'h0000_0008, 1);
    wait_done();
    issue(32'h0000_000C, 1);
    wait_done();

    // Conflict on line 0: 0x080 evicts block 0, then 0x000 misses again.
    issue(32'h0000_0000, 1);
    wait_done();
    issue(32'h0000_0080, 3);
    wait_done();
    issue(32'h0000_0000, 2);
    wait_done();
`ifdef ICACHE_STATS_EN
    check("miss_count_conflict", 32'(miss_count), 32'd3);
`endif

    // Reset during the third MEM_READ cycle of a refill.
    issue(32'h0000_0210, 6);
    repeat (3) @(posedge CLK);
    #2;
    check("mem_read_before_abort", 32'(mem_read), 32'd1);
    do_reset();
    issue(32'h0000_0000, 2);
    wait_done();
    issue(32'h0000_0210, 2);
    wait_done();

    // Pre-reset PC held across reset release must not fetch.
    do_reset();
    repeat (3) begin
      @(negedge CLK);
      check("skip_pc_mem_read", 32'(mem_read), 32'd0);
      check("skip_pc_busywait", 32'(BUSYWAIT), 32'd0);
    end
    @(posedge CLK);
    #1;
    issue(32'h0000_0000, 3);
    wait_done();

    // Top of the address space, then wrap back to block 0.
    do_reset();
    issue(32'h0000_03F0, 2);
    wait_done();
    issue(32'h0000_03FC, 1);
    wait_done();
    issue(32'h0000_0000, 2);
    wait_done();

    // Random mix of sequential runs and jumps, with garbage in the ignored PC bits.
    pc = 32'h0000_0000;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 2) != 0) pc = pc + 32'd4;
      else pc = $urandom;
      if (&pc[31:2]) pc = 32'h0000_0100;
      issue(pc, int'($urandom_range(1, 5)));
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
